mx_rx_ctrl: RTL
===============

// Module: mx_rx_ctrl
// PURPOSE
//  Frame-level sequencer for the Manchester receiver correlator bank.
//  Consumes threshold flags from the preamble, SFD, bit (8-tap @16x) and EOF correlators
//  and walks the frame: IDLE -> PREAMBLE -> DATA -> done/error.
//  Recovers bit timing from bit-correlator hits, assembles bytes and reports frame status.
//  Sits between the correlator instances and the byte FIFO / host interface.
// PARAMETERS
//  BIT_OVS     16   enb_16x ticks per bit period
//  WIN_LO      14   first phase tick (since last hit) at which a bit hit is accepted
//  WIN_HI      18   last phase tick of the acceptance window; must be < 2*BIT_OVS
//  PRE_TMO     64   bit periods allowed between preamble hit and SFD hit
//  MAX_BYTES   255  bytes per frame before overflow error
// PORTS
//  clk       in   1  system clock
//  rst       in   1  asynchronous, active-low reset
//  enb_16x   in   1  16x bit-rate sample enable (single-cycle pulse)
//  pre_h     in   1  preamble correlator high-threshold flag
//  sfd_h     in   1  SFD correlator high-threshold flag
//  bit_h     in   1  bit correlator high flag (mid-bit edge => data 1)
//  bit_l     in   1  bit correlator low flag  (mid-bit edge => data 0)
//  eof_h     in   1  EOF (line idle high) correlator flag
//  cardet    out  1  frame in progress (PREAMBLE or DATA)
//  data      out  8  assembled byte, LSB received first
//  valid     out  1  1-clk pulse, data holds new byte
//  done      out  1  1-clk pulse, frame ended cleanly on EOF
//  err       out  1  1-clk pulse, frame aborted
//  err_code  out  2  reason for last err, held until next err/reset
//  byte_cnt  out  8  bytes delivered in current/last frame
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; all outputs 0; phase, bit and byte counters 0.
//  Flags are sampled only on clk edges where enb_16x=1; all other cycles hold state.
//  IDLE: pre_h -> PREAMBLE, cardet=1, timeout counter cleared.
//  PREAMBLE: sfd_h -> DATA, phase=0, bit_cnt=0, byte_cnt=0.
//   Timeout counts bit periods (BIT_OVS ticks); reaching PRE_TMO -> err, err_code=2'b01, IDLE.
//   sfd_h and timeout on the same tick: sfd_h wins.
//  DATA: phase increments each enb tick, saturating at 2*BIT_OVS-1.
//   Hit = bit_h|bit_l with WIN_LO<=phase<=WIN_HI: shift bit in (bit_h=1, bit_l=0), phase<=0.
//   bit_h and bit_l together: treat as no hit.
//   Hits with phase<WIN_LO are ignored (boundary/half-bit transitions).
//   8th bit: data<=byte, valid=1 on the following clk, byte_cnt++.
//   byte_cnt==MAX_BYTES and another byte completes -> err, err_code=2'b11; byte dropped.
//   phase>WIN_HI with no hit:
//    - eof_h & bit_cnt==0 -> done=1, IDLE.
//    - eof_h & bit_cnt!=0 -> err, err_code=2'b00 (partial byte), IDLE.
//    - else -> err, err_code=2'b10 (lost sync), IDLE.
//  Any err/done: cardet<=0 on the same clk as the pulse; byte_cnt holds until next SFD.
//  valid, done and err are mutually exclusive, each exactly one clk wide.
//  Latency: valid asserts 1 clk after the enb tick carrying the 8th hit.
//  Reset mid-frame: immediate IDLE, no done/err pulse; next frame needs a fresh pre_h.
// STRUCTURE
//  Package mx_rx_pkg: typedef enum logic [1:0] {IDLE, PREAMBLE, DATA} rx_state_t;
//   err_code localparams ERR_PARTIAL=0, ERR_PRE_TMO=1, ERR_SYNC=2, ERR_OVF=3.
//  Sub-module mx_bit_window: phase counter, window compare, hit/miss strobes;
//   parameterised by BIT_OVS/WIN_LO/WIN_HI.
//  Top level holds the FSM, timeout counter, shift register and byte counter.
// TESTING
//  1. Preamble, SFD, bytes 0xA5 and 0x3C, EOF ->
//     valid x2 with data 0xA5 then 0x3C, done=1, byte_cnt=2, err never set.
//  2. Preamble, no SFD for 64 bit periods -> err=1, err_code=01, cardet falls, state IDLE.
//  3. SFD then 3 data bits, then line held high -> err=1, err_code=00, no valid.
//  4. Bit transitions 2 ticks late (phase 18) -> accepted, byte correct;
//     at phase 19 with line toggling (no EOF) -> err_code=10.
//  5. MAX_BYTES=2 override, send 3 bytes -> 2 valid pulses, then err_code=11, byte_cnt=2.
//  6. rst low mid-byte, then a clean frame -> no pulse during reset; second frame received intact.

Source files
------------

// File: rtl/mx_rx_pkg.sv
// Shared types and constants for the Manchester receiver frame sequencer.
//   rx_state_t : frame-level state of mx_rx_ctrl
//   ERR_*      : values reported on err_code_o
package mx_rx_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2
    } rx_state_t;

    localparam logic [1:0] ERR_PARTIAL = 2'd0;
    localparam logic [1:0] ERR_PRE_TMO = 2'd1;
    localparam logic [1:0] ERR_SYNC    = 2'd2;
    localparam logic [1:0] ERR_OVF     = 2'd3;

endpackage

// File: rtl/mx_bit_window.sv
// Bit-timing recovery for the data phase of a frame.
// Tracks enb ticks since the last accepted bit hit and classifies each tick:
//   clk_i    : system clock
//   rst_n_i  : asynchronous active-low reset
//   enb_i    : 16x sample enable
//   run_i    : high while the frame is in the data phase; phase is held at 0 otherwise
//   bit_h_i  : bit correlator high flag
//   bit_l_i  : bit correlator low flag
//   hit_o    : accepted bit on this tick (exactly one flag set, inside the window)
//   bit_o    : value of the accepted bit
//   miss_o   : window closed on this tick without an accepted bit
module mx_bit_window #(
    parameter int BIT_OVS = 16,
    parameter int WIN_LO  = 14,
    parameter int WIN_HI  = 18
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic enb_i,
    input  logic run_i,
    input  logic bit_h_i,
    input  logic bit_l_i,
    output logic hit_o,
    output logic bit_o,
    output logic miss_o
);

    localparam int PW = $clog2(2 * BIT_OVS);
    localparam logic [PW-1:0] PH_MAX   = PW'(2 * BIT_OVS - 1);
    localparam logic [PW-1:0] WIN_LO_P = PW'(WIN_LO);
    localparam logic [PW-1:0] WIN_HI_P = PW'(WIN_HI);

    logic [PW-1:0] phase_q, phase_d;
    logic [PW-1:0] ph_now;
    logic          in_win;

    // ph_now counts the current tick, so a hit exactly one bit period after
    // the previous one is seen at ph_now == BIT_OVS.
    always_comb begin
        ph_now = (phase_q == PH_MAX) ? phase_q : phase_q + PW'(1);
        in_win = (ph_now >= WIN_LO_P) && (ph_now <= WIN_HI_P);
        // both flags together are ambiguous and treated as no hit
        hit_o  = enb_i & run_i & in_win & (bit_h_i ^ bit_l_i);
        bit_o  = bit_h_i;
        miss_o = enb_i & run_i & (ph_now > WIN_HI_P);

        phase_d = phase_q;
        if (!run_i) begin
            phase_d = '0;
        end else if (enb_i) begin
            phase_d = hit_o ? '0 : ph_now;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/mx_rx_ctrl.sv
// Frame-level sequencer for the Manchester receiver correlator bank.
// Walks preamble -> SFD -> data bits -> EOF, assembles bytes and reports status.
//   clk_i       : system clock
//   rst_n_i     : asynchronous active-low reset
//   enb_16x_i   : 16x bit-rate sample enable; flags are only looked at on these ticks
//   pre_h_i     : preamble correlator flag
//   sfd_h_i     : SFD correlator flag
//   bit_h_i     : bit correlator high flag (data 1)
//   bit_l_i     : bit correlator low flag (data 0)
//   eof_h_i     : EOF (line idle high) correlator flag
//   cardet_o    : frame in progress
//   data_o      : last assembled byte, first received bit in bit 0
//   valid_o     : 1-clk pulse, new byte on data_o
//   done_o      : 1-clk pulse, frame ended cleanly
//   err_o       : 1-clk pulse, frame aborted
//   err_code_o  : reason for the last err_o, held until the next one
//   byte_cnt_o  : bytes delivered in the current/last frame
//
// state    | meaning
// IDLE     | waiting for a preamble hit
// PREAMBLE | preamble seen, waiting for SFD, timeout running
// DATA     | receiving bits until EOF, sync loss or overflow
module mx_rx_ctrl
    import mx_rx_pkg::*;
#(
    parameter int BIT_OVS   = 16,
    parameter int WIN_LO    = 14,
    parameter int WIN_HI    = 18,
    parameter int PRE_TMO   = 64,
    parameter int MAX_BYTES = 255
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       enb_16x_i,
    input  logic       pre_h_i,
    input  logic       sfd_h_i,
    input  logic       bit_h_i,
    input  logic       bit_l_i,
    input  logic       eof_h_i,
    output logic       cardet_o,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       done_o,
    output logic       err_o,
    output logic [1:0] err_code_o,
    output logic [7:0] byte_cnt_o
);

    // The preamble timeout is a single tick down-counter covering all PRE_TMO bit periods.
    localparam int TMO_TICKS = PRE_TMO * BIT_OVS;
    localparam int TW        = $clog2(TMO_TICKS + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TMO_TICKS);
    localparam logic [7:0]    MAX_B    = 8'(MAX_BYTES);

    rx_state_t     state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    sh_q, sh_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    byte_cnt_q, byte_cnt_d;
    logic [7:0]    data_q, data_d;
    logic [1:0]    err_code_q, err_code_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic       hit, bit_val, miss;
    logic [7:0] byte_nxt;

    mx_bit_window #(
        .BIT_OVS (BIT_OVS),
        .WIN_LO  (WIN_LO),
        .WIN_HI  (WIN_HI)
    ) u_win (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .enb_i   (enb_16x_i),
        .run_i   (state_q == DATA),
        .bit_h_i (bit_h_i),
        .bit_l_i (bit_l_i),
        .hit_o   (hit),
        .bit_o   (bit_val),
        .miss_o  (miss)
    );

    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        sh_d       = sh_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        data_d     = data_q;
        err_code_d = err_code_q;
        valid_d    = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        byte_nxt   = {bit_val, sh_q[7:1]};

        case (state_q)
            IDLE: begin
                if (enb_16x_i && pre_h_i) begin
                    state_d = PREAMBLE;
                    tmo_d   = TMO_LOAD;
                end
            end
            PREAMBLE: begin
                if (enb_16x_i) begin
                    // SFD takes priority over a timeout on the same tick
                    if (sfd_h_i) begin
                        state_d    = DATA;
                        bit_cnt_d  = '0;
                        byte_cnt_d = '0;
                    end else if (tmo_q == TW'(1)) begin
                        state_d    = IDLE;
                        err_d      = 1'b1;
                        err_code_d = ERR_PRE_TMO;
                    end else begin
                        tmo_d = tmo_q - TW'(1);
                    end
                end
            end
            DATA: begin
                if (hit) begin
                    sh_d      = byte_nxt;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (byte_cnt_q == MAX_B) begin
                            state_d    = IDLE;
                            err_d      = 1'b1;
                            err_code_d = ERR_OVF;
                        end else begin
                            data_d     = byte_nxt;
                            valid_d    = 1'b1;
                            byte_cnt_d = byte_cnt_q + 8'd1;
                        end
                    end
                end else if (miss) begin
                    state_d = IDLE;
                    if (eof_h_i && bit_cnt_q == 3'd0) begin
                        done_d = 1'b1;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = eof_h_i ? ERR_PARTIAL : ERR_SYNC;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            tmo_q      <= '0;
            sh_q       <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            data_q     <= '0;
            err_code_q <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            sh_q       <= sh_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            data_q     <= data_d;
            err_code_q <= err_code_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign cardet_o   = (state_q != IDLE);
    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign err_code_o = err_code_q;
    assign byte_cnt_o = byte_cnt_q;

endmodule
